// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side controller and its helpers:
// FSM state encoding, data-bit count and the default bit period.
package uart_pkg;

    // Data bits per 8N1 frame.
    localparam int unsigned DATA_BITS   = 8;

    // Default bit period in system clocks (100 MHz / 460800 baud).
    localparam int unsigned DEF_CLK_DIV = 217;

    // Smallest bit period the scheduler supports.
    localparam int unsigned MIN_CLK_DIV = 4;

    // Receive scheduler states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        RESYNC = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_line_sync.sv
// Serial-line conditioner: two-flop synchroniser followed by a history flop
// that turns a synchronised 1->0 transition into a one-cycle pulse.
// All flops reset to 1 (idle line level) so reset release never produces a
// spurious falling edge. Also used by the TX-side loopback checker.
module uart_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic line_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchroniser chain plus one-cycle history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign line_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_sample_sched.sv
// UART 8N1 receive scheduler. Detects the start edge, generates the one-cycle
// sample strobe for the attached byte receiver (start, 8 data, stop), checks
// the stop bit, drops words from bad frames and hands good words to the
// consumer through a one-entry valid/ready holding register.
// Optional build macro UART_RX_SAMPLE_SCHED_STATS_EN adds saturating
// good-frame and error counters (o_good_cnt, o_err_cnt).
module uart_rx_sample_sched
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned HALF_DIV = CLK_DIV / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_enable,
    input  logic       i_RX_B,
    output logic       o_SAMPLE_EN,
    input  logic       i_RX_en,
    input  logic [7:0] i_RX_word,
    output logic       o_word_valid,
    output logic [7:0] o_word,
    input  logic       i_word_ready,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_overrun,
    input  logic       i_clr_err
`ifdef UART_RX_SAMPLE_SCHED_STATS_EN
   ,output logic [15:0] o_good_cnt,
    output logic [15:0] o_err_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Line conditioning
    // ------------------------------------------------------------------
    logic line_s;
    logic line_fall;

    uart_line_sync u_line_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (i_RX_B),
        .line_o (line_s),
        .fall_o (line_fall)
    );

    // ------------------------------------------------------------------
    // FSM and baud timing
    // ------------------------------------------------------------------
    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             half_tick;
    logic             bit_tick;
    logic             sample_en;
    logic             stop_bad;

    assign half_tick = (cnt_q == HALF_LAST);
    assign bit_tick  = (cnt_q == BIT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a high line at the start-bit sample is a glitch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (line_fall && i_enable)            state_d = START;
            START:   if (half_tick)                        state_d = line_s ? IDLE : DATA;
            DATA:    if (bit_tick && (idx_q == IDX_LAST))  state_d = STOP;
            STOP:    if (bit_tick)                         state_d = line_s ? IDLE : RESYNC;
            RESYNC:  if (bit_tick && line_s)               state_d = IDLE;
            default:                                       state_d = IDLE;
        endcase
    end

    // Strobe and stop-check outputs, decoded from state, count and line.
    always_comb begin
        sample_en = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            START:  sample_en = half_tick & ~line_s;
            DATA:   sample_en = bit_tick;
            STOP: begin
                sample_en = bit_tick;
                stop_bad  = bit_tick & ~line_s;
            end
            RESYNC: sample_en = bit_tick;
            default: ;
        endcase
    end

    // Baud counter restarts on every state entry and after each strobe so
    // every strobe is exactly one bit period after the previous one; the
    // bit index counts data strobes.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if ((state_d != state_q) || sample_en) cnt_d = '0;
        idx_d = idx_q;
        if (state_q == START)                  idx_d = 3'd0;
        else if (state_q == DATA && bit_tick)  idx_d = idx_q + 3'd1;
    end

    // Baud counter and bit index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Word hand-off and sticky status
    // ------------------------------------------------------------------
    logic       disc_q, disc_d;
    logic       valid_q, valid_d;
    logic [7:0] word_q, word_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;
    logic       transfer;
    logic       good_word;
    logic       load;
    logic       overrun_ev;

    // A word that arrives in the very cycle the bad stop bit is seen is
    // dropped too, so receivers that report on the stop strobe itself work.
    always_comb begin
        transfer   = valid_q & i_word_ready;
        good_word  = i_RX_en & ~(disc_q | stop_bad);
        load       = good_word & (~valid_q | transfer);
        overrun_ev = good_word & valid_q & ~transfer;

        disc_d  = i_RX_en ? 1'b0 : (disc_q | stop_bad);
        valid_d = load ? 1'b1 : (transfer ? 1'b0 : valid_q);
        word_d  = load ? i_RX_word : word_q;
        ferr_d  = stop_bad   | (ferr_q & ~i_clr_err);
        ovr_d   = overrun_ev | (ovr_q  & ~i_clr_err);
    end

    // Holding register, discard flag and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disc_q  <= 1'b0;
            valid_q <= 1'b0;
            word_q  <= 8'h00;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            disc_q  <= disc_d;
            valid_q <= valid_d;
            word_q  <= word_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_SAMPLE_EN  = sample_en;
    assign o_busy       = (state_q != IDLE);
    assign o_word_valid = valid_q;
    assign o_word       = word_q;
    assign o_frame_err  = ferr_q;
    assign o_overrun    = ovr_q;

`ifdef UART_RX_SAMPLE_SCHED_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters (saturating; events in a clearing cycle count)
    // ------------------------------------------------------------------
    logic [15:0] good_q, good_d;
    logic [15:0] err_q,  err_d;
    logic [15:0] good_base, err_base;
    logic [16:0] err_sum;

    // Next counter values: clear first, then add this cycle's events.
    always_comb begin
        good_base = i_clr_err ? 16'h0000 : good_q;
        err_base  = i_clr_err ? 16'h0000 : err_q;
        good_d    = good_base;
        if (load && (good_base != 16'hFFFF)) good_d = good_base + 16'd1;
        err_sum   = {1'b0, err_base} + {15'd0, stop_bad} + {15'd0, overrun_ev};
        err_d     = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_q <= 16'h0000;
            err_q  <= 16'h0000;
        end else begin
            good_q <= good_d;
            err_q  <= err_d;
        end
    end

    assign o_good_cnt = good_q;
    assign o_err_cnt  = err_q;
`endif

endmodule

// File: tb/tb_uart_rx_sample_sched.sv
// Directed + randomized bench for uart_rx_sample_sched with CLK_DIV=8.
// A behavioural byte receiver hangs off the strobe; expected strobe times,
// strobe counts and delivered words come from frame-level arithmetic.
module tb_uart_rx_sample_sched;

    localparam int CLK_DIV = 8;
    localparam int HALF    = CLK_DIV / 2;
    localparam int SYNC_LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_enable = 1'b0;
    logic       i_RX_B = 1'b1;
    logic       i_RX_en = 1'b0;
    logic [7:0] i_RX_word = 8'h00;
    logic       i_word_ready = 1'b0;
    logic       i_clr_err = 1'b0;
    logic       o_SAMPLE_EN;
    logic       o_word_valid;
    logic [7:0] o_word;
    logic       o_busy;
    logic       o_frame_err;
    logic       o_overrun;
`ifdef UART_RX_SAMPLE_SCHED_STATS_EN
    logic [15:0] o_good_cnt;
    logic [15:0] o_err_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;
    int pulses[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // receiver model state
    int         rk  = 0;
    logic [7:0] rsh = 8'h00;

    uart_rx_sample_sched #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (i_enable),
        .i_RX_B       (i_RX_B),
        .o_SAMPLE_EN  (o_SAMPLE_EN),
        .i_RX_en      (i_RX_en),
        .i_RX_word    (i_RX_word),
        .o_word_valid (o_word_valid),
        .o_word       (o_word),
        .i_word_ready (i_word_ready),
        .o_busy       (o_busy),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun),
        .i_clr_err    (i_clr_err)
`ifdef UART_RX_SAMPLE_SCHED_STATS_EN
       ,.o_good_cnt   (o_good_cnt),
        .o_err_cnt    (o_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe timestamps and consumer transfers, sampled mid-cycle.
    always @(negedge clk) begin
        if (o_SAMPLE_EN) pulses.push_back(cyc);
        if (o_word_valid && i_word_ready) got_q.push_back(o_word);
    end

    // Byte receiver: start, 8 data bits LSB first, stop -> word pulse;
    // after a low stop it waits for a strobe that sees the line high.
    always @(negedge clk) begin
        i_RX_en = 1'b0;
        if (!rst_n) rk = 0;
        else if (o_SAMPLE_EN) begin
            if (rk == 0) rk = 1;
            else if (rk <= 8) begin rsh[rk-1] = i_RX_B; rk++; end
            else if (rk == 9) begin
                i_RX_word = rsh;
                i_RX_en   = 1'b1;
                rk        = i_RX_B ? 0 : 10;
            end
            else if (i_RX_B) rk = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int stop_low, input bit drop_en,
                              output int t0);
        @(posedge clk); #1;
        t0 = cyc;
        i_RX_B = 1'b0; tick(CLK_DIV);
        if (drop_en) i_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin i_RX_B = b[i]; tick(CLK_DIV); end
        if (stop_low > 0) begin i_RX_B = 1'b0; tick(CLK_DIV * stop_low); end
        i_RX_B = 1'b1; tick(CLK_DIV);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_busy && n < 200) begin tick(1); n++; end
        check(tag, 32'(o_busy), 32'd0);
    endtask

    task automatic pop_word(input string tag);
        i_word_ready = 1'b1; tick(1); i_word_ready = 1'b0;
        check(tag, 32'(o_word_valid), 32'd0);
    endtask

    task automatic clr_pulse();
        i_clr_err = 1'b1; tick(1); i_clr_err = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int t0;
        int t1;
        int nl;
        logic [7:0] b;

        // reset state
        tick(3);
        check("rst_sample", 32'(o_SAMPLE_EN), 0);
        check("rst_valid",  32'(o_word_valid), 0);
        check("rst_word",   32'(o_word), 0);
        check("rst_busy",   32'(o_busy), 0);
        check("rst_ferr",   32'(o_frame_err), 0);
        check("rst_ovr",    32'(o_overrun), 0);
        rst_n = 1'b1; i_enable = 1'b1; tick(4);

        // good frame 0xA5: strobe timing and delivery
        p0 = pulses.size();
        send_frame(8'hA5, 0, 1'b0, t0);
        wait_idle("a5_idle");
        check("a5_npulse", 32'(pulses.size() - p0), 32'd10);
        for (int k = 0; k < 10; k++)
            if (p0 + k < pulses.size())
                check($sformatf("a5_pulse%0d", k), 32'(pulses[p0+k]),
                      32'(t0 + SYNC_LAT + HALF + k * CLK_DIV));
        check("a5_valid", 32'(o_word_valid), 1);
        check("a5_word",  32'(o_word), 32'hA5);
        exp_q.push_back(8'hA5);
        pop_word("a5_pop");

        // two-cycle glitch
        p0 = pulses.size();
        i_RX_B = 1'b0; tick(2); i_RX_B = 1'b1; tick(2);
        check("gl_busy", 32'(o_busy), 1);
        tick(HALF);
        check("gl_idle", 32'(o_busy), 0);
        tick(20);
        check("gl_npulse", 32'(pulses.size() - p0), 0);
        check("gl_valid",  32'(o_word_valid), 0);

        // bad stop for two bit times, then a good frame
        p0 = pulses.size();
        send_frame(8'h3C, 2, 1'b0, t0);
        wait_idle("fe_idle");
        check("fe_npulse", 32'(pulses.size() - p0), 32'd12);
        check("fe_ferr",   32'(o_frame_err), 1);
        check("fe_valid",  32'(o_word_valid), 0);
        send_frame(8'h55, 0, 1'b0, t0);
        wait_idle("fe55_idle");
        check("fe55_valid", 32'(o_word_valid), 1);
        check("fe55_word",  32'(o_word), 32'h55);
        check("fe55_ferr",  32'(o_frame_err), 1);
        clr_pulse();
        check("fe_clr", 32'(o_frame_err), 0);
        exp_q.push_back(8'h55);
        pop_word("fe55_pop");

        // overrun; clear held during the overrun event must lose
        send_frame(8'h11, 0, 1'b0, t0);
        fork
            send_frame(8'h22, 0, 1'b0, t1);
            begin
                @(posedge clk); #1;
                tick(SYNC_LAT + HALF + 9 * CLK_DIV);
                i_clr_err = 1'b1; tick(1); i_clr_err = 1'b0;
            end
        join
        wait_idle("ov_idle");
        check("ov_valid", 32'(o_word_valid), 1);
        check("ov_word",  32'(o_word), 32'h11);
        check("ov_flag",  32'(o_overrun), 1);
        exp_q.push_back(8'h11);
        pop_word("ov_pop");
        clr_pulse();
        check("ov_clr", 32'(o_overrun), 0);

        // asynchronous reset in the middle of data bit 4
        send_frame(8'h33, 0, 1'b0, t0);
        @(posedge clk); #1;
        i_RX_B = 1'b0; tick(CLK_DIV);
        b = 8'h81;
        for (int i = 0; i < 4; i++) begin i_RX_B = b[i]; tick(CLK_DIV); end
        i_RX_B = b[4]; tick(CLK_DIV / 2);
        check("rs_busy_pre", 32'(o_busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_busy",   32'(o_busy), 0);
        check("rs_valid",  32'(o_word_valid), 0);
        check("rs_word",   32'(o_word), 0);
        check("rs_sample", 32'(o_SAMPLE_EN), 0);
        i_RX_B = 1'b1; tick(3); rst_n = 1'b1; tick(4);
        p0 = pulses.size();
        send_frame(8'h81, 0, 1'b0, t0);
        wait_idle("rs81_idle");
        check("rs81_npulse", 32'(pulses.size() - p0), 32'd10);
        check("rs81_word",   32'(o_word), 32'h81);
        exp_q.push_back(8'h81);
        pop_word("rs81_pop");

        // enable dropped mid-frame, then a frame while disabled
        p0 = pulses.size();
        send_frame(8'h5A, 0, 1'b1, t0);
        wait_idle("en_idle");
        check("en_npulse", 32'(pulses.size() - p0), 32'd10);
        check("en_word",   32'(o_word), 32'h5A);
        exp_q.push_back(8'h5A);
        pop_word("en_pop");
        p0 = pulses.size();
        send_frame(8'hC3, 0, 1'b0, t0);
        check("dis_npulse", 32'(pulses.size() - p0), 0);
        check("dis_busy",   32'(o_busy), 0);
        check("dis_valid",  32'(o_word_valid), 0);
        i_enable = 1'b1; tick(4);
        p0 = pulses.size();
        send_frame(8'h96, 0, 1'b0, t0);
        wait_idle("en96_idle");
        check("en96_word", 32'(o_word), 32'h96);
        exp_q.push_back(8'h96);
        pop_word("en96_pop");

        // random frames, consumer always ready, occasional bad stop
        i_word_ready = 1'b1;
        for (int f = 0; f < 10; f++) begin
            b  = 8'($urandom);
            nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            p0 = pulses.size();
            send_frame(b, nl, 1'b0, t0);
            wait_idle($sformatf("rnd%0d_idle", f));
            check($sformatf("rnd%0d_npulse", f), 32'(pulses.size() - p0), 32'(10 + nl));
            check($sformatf("rnd%0d_ferr", f), 32'(o_frame_err), 32'(nl > 0));
            if (nl == 0) exp_q.push_back(b);
            clr_pulse();
            tick(int'($urandom_range(0, 5)));
        end
        i_word_ready = 1'b0;
        tick(2);

        // everything the consumer took, in order
        check("q_size", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size())
                check($sformatf("q_word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_sample_sched.md
Name: uart_rx_sample_sched

Overview:
- Controller for the 8N1 UART byte receiver that sits beside it. It owns the receiver's one-cycle sample-enable strobe, timed from its own start-edge detection.
- Checks the stop bit and discards words from bad frames. Passes good words to the consumer through a one-entry valid/ready holding register.
- Sits between the serial pad and the consumer, with the receiver hanging off it.

Parameters:
- CLK_DIV, 217, clock cycles per bit (100 MHz / 460800); legal minimum 4.
- HALF_DIV, CLK_DIV/2, cycles from start-edge detection to the start-bit sample strobe.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  allow new frames to start
- i_RX_B  in  1  raw serial line (same net as receiver input)
- o_SAMPLE_EN  out  1  one-cycle sample strobe to receiver
- i_RX_en  in  1  receiver word-done pulse
- i_RX_word  in  8  receiver word, valid with i_RX_en
- o_word_valid  out  1  holding register full
- o_word  out  8  held word
- i_word_ready  in  1  consumer accepts; transfer when valid & ready
- o_busy  out  1  frame in progress (state != IDLE)
- o_frame_err  out  1  sticky: stop bit sampled low
- o_overrun  out  1  sticky: good word arrived while holding register full
- i_clr_err  in  1  pulse: clears both sticky flags

Behaviour:
- Reset (asynchronous): state IDLE, baud counter 0, all outputs 0, line synchroniser flops 1.
- Line path: two-flop synchroniser, then a third flop for edge detection. A falling edge is synchronised-previous 1 and synchronised-current 0.
- Baud counter width is clog2(CLK_DIV). It is cleared on every state entry and increments each cycle otherwise.
- States and transitions:
  - IDLE: on a falling edge with i_enable=1, counter to 0 and go to START.
  - START: at count HALF_DIV-1, sample the synchronised line.
    - Low: pulse o_SAMPLE_EN, bit index 0, go to DATA.
    - High: treat as glitch, no pulse, go to IDLE.
  - DATA: at each count CLK_DIV-1, pulse o_SAMPLE_EN and increment bit index. After the 8th pulse go to STOP.
  - STOP: at count CLK_DIV-1, pulse o_SAMPLE_EN and sample the line.
    - High: go to IDLE.
    - Low: set o_frame_err, arm discard flag, go to RESYNC.
  - RESYNC: at each count CLK_DIV-1, pulse o_SAMPLE_EN. Leave for IDLE on the first pulse where the line is high; the receiver leaves its end state on that same pulse.
- Each good frame produces exactly 10 o_SAMPLE_EN pulses: start + 8 data + stop. Pulses are always exactly one cycle wide.
- i_enable only gates the IDLE->START transition. Deasserting it mid-frame lets the frame complete.
- Word handling on i_RX_en:
  - Discard flag set: drop the word and clear the flag.
  - Else, holding register empty or transferring this cycle: load o_word and set o_word_valid next cycle.
  - Else: drop the new word, keep the old one, set o_overrun.
- o_word_valid clears on valid & ready unless reloaded the same cycle. o_word is held stable while valid.
- i_clr_err clears the sticky flags. If a set event coincides with the clear, the set wins.
- Falling edges outside IDLE are ignored.

Optional Feature:
- Macro UART_RX_SAMPLE_SCHED_STATS_EN.
- Defined:
  - Adds o_good_cnt[15:0] (frames delivered to the holding register) and o_err_cnt[15:0] (framing errors plus overruns).
  - Both counters saturate at 16'hFFFF and clear on reset or i_clr_err.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Decomposition:
- Shared package uart_pkg:
  - state encoding: IDLE, START, DATA, STOP, RESYNC
  - localparams for data-bit count (8) and default CLK_DIV
- One natural sub-module, uart_line_sync: two-flop synchroniser plus falling-edge pulse, reusable by the TX-side loopback checker.
- The baud counter and FSM stay inline.

Test Plan:
- CLK_DIV=8, send 0xA5 (8N1, bits of 8 clocks) -> 10 strobes, first 4 cycles after edge detection then every 8 cycles; receiver outputs 0xA5; o_word_valid=1, o_word=0xA5.
- 2-cycle low glitch on idle line -> no o_SAMPLE_EN, o_busy returns 0 after HALF_DIV cycles, receiver stays idle.
- Frame 0x3C with stop bit low for 2 bit times, then high -> o_frame_err=1, RESYNC strobes until line high, receiver word discarded (o_word_valid stays 0); next frame 0x55 delivered normally.
- i_word_ready=0, send 0x11 then 0x22 -> o_word=0x11 held, o_overrun=1; raise ready -> 0x11 transferred, valid drops; i_clr_err -> o_overrun=0.
- Assert rst_n=0 in the middle of data bit 4 -> outputs 0 immediately, state IDLE; after release the next full frame 0x81 is received correctly.
- i_enable=0 during a frame -> frame completes; following start edge ignored until i_enable=1.
